// File: rtl/ysyx_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory-bus arbiter: owner state encoding,
// the fixed IFU read strobe and the response-timer width helper.
package ysyx_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_IFU_RD = 2'd1,
        ARB_LSU_RD = 2'd2,
        ARB_LSU_WR = 2'd3
    } arb_state_e;

    // Instruction fetches always read a full 32-bit word.
    localparam logic [7:0] IFU_RSTRB = 8'h0f;

    // A limit of 0 disables the timer but still needs a 1-bit counter.
    function automatic int timer_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/ysyx_bus_timer.sv
// Response watchdog: counts busy cycles since the last clear and flags the
// cycle on which the count reaches TIMEOUT_CYC (never, when TIMEOUT_CYC is 0).
module ysyx_bus_timer
    import ysyx_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = timer_width(TIMEOUT_CYC);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [CW-1:0] r_count;

    // Saturates at the limit so a disabled or expired timer never wraps.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_expire = (TIMEOUT_CYC != 0) && i_enable && (r_count == LIMIT);

endmodule

// File: rtl/ysyx_mem_arbiter.sv
// Non-preemptive arbiter sharing one memory-bus master port between the IFU
// and the LSU; one transaction in flight, request fields latched at grant.
module ysyx_mem_arbiter
    import ysyx_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_rvalid,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    input  logic [7:0]        lsu_rstrb,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rvalid,
    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic              lsu_awvalid,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wstrb,
    output logic              lsu_wready,
    output logic              bus_err_o,
    output logic [ADDR_W-1:0] bus_araddr_o,
    output logic              bus_arvalid_o,
    output logic [7:0]        bus_rstrb_o,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_rvalid,
    output logic [ADDR_W-1:0] bus_awaddr_o,
    output logic              bus_awvalid_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    output logic [7:0]        bus_wstrb_o,
    output logic              bus_wvalid_o,
    input  logic              bus_wready,
    output logic [1:0]        o_dbg_state
);

    // Handshake: requesters hold a level valid until their one-cycle completion
    // pulse; downstream valids are registered and held until bus_rvalid /
    // bus_wready (same-cycle completion) or the timer expires.

    arb_state_e        r_state, w_next;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [7:0]        r_strb, w_strb;
    logic [DATA_W-1:0] r_wdata, w_wdata;

    logic w_rd_busy, w_wr_busy, w_busy;
    logic w_done, w_expire, w_timeout, w_finish;

    assign w_rd_busy = (r_state == ARB_IFU_RD) || (r_state == ARB_LSU_RD);
    assign w_wr_busy = (r_state == ARB_LSU_WR);
    assign w_busy    = w_rd_busy || w_wr_busy;
    assign w_done    = (w_rd_busy && bus_rvalid) || (w_wr_busy && bus_wready);
    assign w_timeout = w_expire && !w_done;
    assign w_finish  = w_done || w_expire;

    ysyx_bus_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (r_state == ARB_IDLE),
        .i_enable(w_busy),
        .o_expire(w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_addr  <= '0;
            r_strb  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            r_addr  <= w_addr;
            r_strb  <= w_strb;
            r_wdata <= w_wdata;
        end
    end

    // Stores beat loads, loads beat fetches; busy states ignore all requests.
    always_comb begin
        w_next  = r_state;
        w_addr  = r_addr;
        w_strb  = r_strb;
        w_wdata = r_wdata;
        case (r_state)
            ARB_IDLE: begin
                if (lsu_awvalid) begin
                    w_next  = ARB_LSU_WR;
                    w_addr  = lsu_awaddr;
                    w_strb  = lsu_wstrb;
                    w_wdata = lsu_wdata;
                end else if (lsu_arvalid) begin
                    w_next  = ARB_LSU_RD;
                    w_addr  = lsu_araddr;
                    w_strb  = lsu_rstrb;
                    w_wdata = '0;
                end else if (ifu_arvalid) begin
                    w_next  = ARB_IFU_RD;
                    w_addr  = ifu_araddr;
                    w_strb  = IFU_RSTRB;
                    w_wdata = '0;
                end
            end
            default: begin
                if (w_finish) begin
                    w_next = ARB_IDLE;
                end
            end
        endcase
    end

    assign bus_arvalid_o = w_rd_busy;
    assign bus_araddr_o  = w_rd_busy ? r_addr : '0;
    assign bus_rstrb_o   = w_rd_busy ? r_strb : '0;
    assign bus_awvalid_o = w_wr_busy;
    assign bus_wvalid_o  = w_wr_busy;
    assign bus_awaddr_o  = w_wr_busy ? r_addr  : '0;
    assign bus_wdata_o   = w_wr_busy ? r_wdata : '0;
    assign bus_wstrb_o   = w_wr_busy ? r_strb  : '0;

    // A timeout completes the owner with zero data and raises bus_err_o.
    assign ifu_rvalid = (r_state == ARB_IFU_RD) && w_finish;
    assign ifu_rdata  = ((r_state == ARB_IFU_RD) && bus_rvalid) ? bus_rdata : '0;
    assign lsu_rvalid = (r_state == ARB_LSU_RD) && w_finish;
    assign lsu_rdata  = ((r_state == ARB_LSU_RD) && bus_rvalid) ? bus_rdata : '0;
    assign lsu_wready = w_wr_busy && w_finish;
    assign bus_err_o  = w_timeout;

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// Directed bench for ysyx_mem_arbiter: transaction-level owner model checked
// every cycle, plus hand-computed literal expectations per scenario.
module tb_ysyx_mem_arbiter;
    import ysyx_mem_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    localparam int OWN_NONE = 0;
    localparam int OWN_IFU  = 1;
    localparam int OWN_LD   = 2;
    localparam int OWN_ST   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] ifu_araddr, lsu_araddr, lsu_awaddr;
    logic          ifu_arvalid, lsu_arvalid, lsu_awvalid;
    logic [7:0]    lsu_rstrb, lsu_wstrb;
    logic [DW-1:0] lsu_wdata, bus_rdata;
    logic          bus_rvalid, bus_wready;
    logic [DW-1:0] ifu_rdata, lsu_rdata, bus_wdata_o;
    logic          ifu_rvalid, lsu_rvalid, lsu_wready, bus_err_o;
    logic [AW-1:0] bus_araddr_o, bus_awaddr_o;
    logic          bus_arvalid_o, bus_awvalid_o, bus_wvalid_o;
    logic [7:0]    bus_rstrb_o, bus_wstrb_o;
    logic [1:0]    o_dbg_state;

    ysyx_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
        .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wready(lsu_wready),
        .bus_err_o(bus_err_o),
        .bus_araddr_o(bus_araddr_o), .bus_arvalid_o(bus_arvalid_o), .bus_rstrb_o(bus_rstrb_o),
        .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
        .bus_awaddr_o(bus_awaddr_o), .bus_awvalid_o(bus_awvalid_o),
        .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o), .bus_wvalid_o(bus_wvalid_o),
        .bus_wready(bus_wready),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    bit model_on = 1'b0;
    logic [DW-1:0] exp_q[$];
    int cnt_ifu = 0, cnt_lsu_r = 0, cnt_lsu_w = 0, cnt_err = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The bus belongs to at most one owner; it keeps the request it was granted
    // until the slave answers or TO cycles have passed since issue.
    int          m_owner = OWN_NONE;
    logic [31:0] m_addr  = '0;
    logic [7:0]  m_strb  = '0;
    logic [31:0] m_data  = '0;
    int          m_age   = 0;

    always @(negedge clk) begin
        bit rd, wr, done, tmo, fin;
        logic [1:0] e_state;
        if (model_on) begin
            rd   = (m_owner == OWN_IFU) || (m_owner == OWN_LD);
            wr   = (m_owner == OWN_ST);
            done = (rd && bus_rvalid) || (wr && bus_wready);
            tmo  = (rd || wr) && (m_age == TO) && !done;
            fin  = done || tmo;
            case (m_owner)
                OWN_IFU: e_state = ARB_IFU_RD;
                OWN_LD:  e_state = ARB_LSU_RD;
                OWN_ST:  e_state = ARB_LSU_WR;
                default: e_state = ARB_IDLE;
            endcase
            chk("ifu_resp", {ifu_rvalid, ifu_rdata},
                {(m_owner == OWN_IFU) && fin, ((m_owner == OWN_IFU) && done) ? bus_rdata : 32'h0});
            chk("lsu_resp", {lsu_rvalid, lsu_wready, bus_err_o, lsu_rdata},
                {(m_owner == OWN_LD) && fin, wr && fin, tmo,
                 ((m_owner == OWN_LD) && done) ? bus_rdata : 32'h0});
            chk("bus_rd", {bus_arvalid_o, bus_rstrb_o, bus_araddr_o},
                {rd, rd ? m_strb : 8'h0, rd ? m_addr : 32'h0});
            chk("bus_wr", {bus_awvalid_o, bus_wvalid_o, bus_wstrb_o, bus_awaddr_o, bus_wdata_o},
                {wr, wr, wr ? m_strb : 8'h0, wr ? m_addr : 32'h0, wr ? m_data : 32'h0});
            chk("state", o_dbg_state, e_state);
            if (rst) begin
                m_owner = OWN_NONE;
            end else if (m_owner == OWN_NONE) begin
                m_age = 0;
                if (lsu_awvalid) begin
                    m_owner = OWN_ST; m_addr = lsu_awaddr; m_strb = lsu_wstrb; m_data = lsu_wdata;
                end else if (lsu_arvalid) begin
                    m_owner = OWN_LD; m_addr = lsu_araddr; m_strb = lsu_rstrb;
                end else if (ifu_arvalid) begin
                    m_owner = OWN_IFU; m_addr = ifu_araddr; m_strb = 8'h0f;
                end
            end else if (fin) begin
                m_owner = OWN_NONE;
            end else begin
                m_age++;
            end
        end
    end

    // ---------------- scoreboard on read completions ----------------
    always @(negedge clk) begin
        if (model_on) begin
            if (ifu_rvalid) cnt_ifu++;
            if (lsu_rvalid) cnt_lsu_r++;
            if (lsu_wready) cnt_lsu_w++;
            if (bus_err_o)  cnt_err++;
            if (ifu_rvalid || lsu_rvalid) begin
                chk("rd_queue_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) chk("rd_data", ifu_rdata | lsu_rdata, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_issue(input string name, input bit want_wr);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (want_wr ? bus_awvalid_o : bus_arvalid_o) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk(name, ok, 1'b1);
    endtask

    // who: 1 = IFU owns the read, 2 = LSU owns it.
    task automatic read_resp(input int delay, input logic [31:0] data, input int who);
        repeat (delay) step();
        bus_rvalid = 1'b1;
        bus_rdata  = data;
        #1;
        chk("resp_owner", {ifu_rvalid, lsu_rvalid}, (who == 1) ? 2'b10 : 2'b01);
        step();
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
    endtask

    task automatic write_resp(input int delay);
        repeat (delay) step();
        bus_wready = 1'b1;
        #1;
        chk("wr_resp", {lsu_wready, lsu_rvalid, ifu_rvalid, bus_err_o}, 4'b1000);
        step();
        bus_wready = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int c_ifu, c_lr, c_lw, c_err;
        rst = 1'b1;
        ifu_araddr = '0; ifu_arvalid = 1'b0;
        lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_rstrb = '0;
        lsu_awaddr = '0; lsu_awvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0;
        bus_rdata = '0; bus_rvalid = 1'b0; bus_wready = 1'b0;
        step();
        step();
        model_on = 1'b1;
        chk("reset_outputs",
            {ifu_rvalid, lsu_rvalid, lsu_wready, bus_err_o, bus_arvalid_o, bus_awvalid_o,
             bus_wvalid_o, bus_araddr_o, bus_awaddr_o, bus_wdata_o, bus_rstrb_o, bus_wstrb_o,
             ifu_rdata, lsu_rdata, o_dbg_state}, '0);
        step();
        rst = 1'b0;
        step();

        // Done strobes with nobody owning the bus are ignored.
        bus_rvalid = 1'b1; bus_wready = 1'b1; bus_rdata = 32'h1111_2222;
        #1;
        chk("idle_strobes", {ifu_rvalid, lsu_rvalid, lsu_wready, bus_err_o}, 4'b0000);
        step();
        bus_rvalid = 1'b0; bus_wready = 1'b0; bus_rdata = '0;
        step();

        // IFU fetch, slave answers 3 cycles after issue.
        c_ifu = cnt_ifu; c_lr = cnt_lsu_r;
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
        wait_issue("t1_issue", 1'b0);
        chk("t1_bus_rd", {bus_araddr_o, bus_rstrb_o}, {32'h8000_0000, 8'h0f});
        exp_q.push_back(32'h0000_0413);
        read_resp(3, 32'h0000_0413, 1);
        ifu_arvalid = 1'b0;
        chk("t1_pulses", {cnt_ifu - c_ifu, cnt_lsu_r - c_lr}, {32'd1, 32'd0});
        step();

        // IFU and LSU load together: LSU first, IFU right after.
        c_ifu = cnt_ifu; c_lr = cnt_lsu_r;
        ifu_araddr = 32'h8000_0004; ifu_arvalid = 1'b1;
        lsu_araddr = 32'h8000_2000; lsu_rstrb = 8'h03; lsu_arvalid = 1'b1;
        wait_issue("t2_issue_lsu", 1'b0);
        chk("t2_bus_lsu", {bus_araddr_o, bus_rstrb_o}, {32'h8000_2000, 8'h03});
        exp_q.push_back(32'h1234_5678);
        read_resp(1, 32'h1234_5678, 2);
        lsu_arvalid = 1'b0;
        wait_issue("t2_issue_ifu", 1'b0);
        chk("t2_bus_ifu", {bus_araddr_o, bus_rstrb_o}, {32'h8000_0004, 8'h0f});
        exp_q.push_back(32'h0000_0093);
        read_resp(0, 32'h0000_0093, 1);
        ifu_arvalid = 1'b0;
        chk("t2_pulses", {cnt_ifu - c_ifu, cnt_lsu_r - c_lr}, {32'd1, 32'd1});
        step();

        // Store with request fields changed while busy; read strobe ignored in LSU_WR.
        c_lw = cnt_lsu_w; c_ifu = cnt_ifu;
        lsu_awaddr = 32'h8000_1000; lsu_wdata = 32'hdead_beef; lsu_wstrb = 8'h03; lsu_awvalid = 1'b1;
        wait_issue("t3_issue", 1'b1);
        step();
        lsu_awaddr = 32'h1234_0000; lsu_wdata = 32'h0; lsu_wstrb = 8'hff;
        ifu_araddr = 32'h8000_0008; ifu_arvalid = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'h5555_5555;
        #1;
        chk("t3_wrong_done", {lsu_rvalid, ifu_rvalid, lsu_wready}, 3'b000);
        step();
        bus_rvalid = 1'b0; bus_rdata = '0;
        chk("t3_latched", {bus_awvalid_o, bus_wvalid_o, bus_awaddr_o, bus_wdata_o, bus_wstrb_o},
            {1'b1, 1'b1, 32'h8000_1000, 32'hdead_beef, 8'h03});
        write_resp(0);
        lsu_awvalid = 1'b0;
        wait_issue("t3_issue_ifu", 1'b0);
        chk("t3_bus_ifu", bus_araddr_o, 32'h8000_0008);
        exp_q.push_back(32'h0000_0013);
        read_resp(2, 32'h0000_0013, 1);
        ifu_arvalid = 1'b0;
        chk("t3_pulses", {cnt_lsu_w - c_lw, cnt_ifu - c_ifu}, {32'd1, 32'd1});
        step();

        // Silent slave: error completion exactly TO cycles after issue.
        c_lr = cnt_lsu_r; c_err = cnt_err;
        lsu_araddr = 32'h8000_3000; lsu_rstrb = 8'h0f; lsu_arvalid = 1'b1;
        wait_issue("t4_issue", 1'b0);
        exp_q.push_back(32'h0);
        repeat (TO - 1) step();
        chk("t4_not_yet", {lsu_rvalid, bus_err_o}, 2'b00);
        step();
        chk("t4_timeout", {lsu_rvalid, bus_err_o, lsu_rdata}, {1'b1, 1'b1, 32'h0});
        step();
        lsu_arvalid = 1'b0;
        chk("t4_idle", {bus_arvalid_o, o_dbg_state}, {1'b0, ARB_IDLE});
        chk("t4_pulses", {cnt_lsu_r - c_lr, cnt_err - c_err}, {32'd1, 32'd1});
        step();

        // Answer on the expiry cycle is a normal completion.
        c_err = cnt_err;
        lsu_araddr = 32'h8000_3004; lsu_arvalid = 1'b1;
        wait_issue("t4b_issue", 1'b0);
        exp_q.push_back(32'h5a5a_0001);
        repeat (TO) step();
        bus_rvalid = 1'b1; bus_rdata = 32'h5a5a_0001;
        #1;
        chk("t4b_on_expiry", {lsu_rvalid, bus_err_o, lsu_rdata}, {1'b1, 1'b0, 32'h5a5a_0001});
        step();
        bus_rvalid = 1'b0; bus_rdata = '0;
        lsu_arvalid = 1'b0;
        chk("t4b_no_err", cnt_err - c_err, 32'd0);
        step();

        // Reset mid-load, then a late response that must be dropped.
        c_lr = cnt_lsu_r;
        lsu_araddr = 32'h8000_4000; lsu_rstrb = 8'h01; lsu_arvalid = 1'b1;
        wait_issue("t5_issue", 1'b0);
        step();
        rst = 1'b1; lsu_arvalid = 1'b0;
        step();
        rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hcafe_f00d;
        #1;
        chk("t5_late_resp", {lsu_rvalid, bus_arvalid_o, lsu_rdata, o_dbg_state},
            {1'b0, 1'b0, 32'h0, ARB_IDLE});
        step();
        bus_rvalid = 1'b0; bus_rdata = '0;
        chk("t5_no_pulse", cnt_lsu_r - c_lr, 32'd0);
        ifu_araddr = 32'h8000_000c; ifu_arvalid = 1'b1;
        wait_issue("t5_issue_ifu", 1'b0);
        exp_q.push_back(32'h0010_0093);
        read_resp(1, 32'h0010_0093, 1);
        ifu_arvalid = 1'b0;
        step();

        // Store and load together: write first, then the pending load.
        c_lr = cnt_lsu_r; c_lw = cnt_lsu_w;
        lsu_awaddr = 32'h8000_5000; lsu_wdata = 32'h0102_0304; lsu_wstrb = 8'h0f; lsu_awvalid = 1'b1;
        lsu_araddr = 32'h8000_6000; lsu_rstrb = 8'h01; lsu_arvalid = 1'b1;
        wait_issue("t6_issue_wr", 1'b1);
        chk("t6_wr_only", {bus_arvalid_o, bus_awaddr_o, bus_wdata_o}, {1'b0, 32'h8000_5000, 32'h0102_0304});
        write_resp(1);
        lsu_awvalid = 1'b0;
        wait_issue("t6_issue_rd", 1'b0);
        chk("t6_bus_rd", {bus_araddr_o, bus_rstrb_o}, {32'h8000_6000, 8'h01});
        exp_q.push_back(32'h0000_00ab);
        read_resp(0, 32'h0000_00ab, 2);
        lsu_arvalid = 1'b0;
        chk("t6_pulses", {cnt_lsu_w - c_lw, cnt_lsu_r - c_lr}, {32'd1, 32'd1});

        repeat (3) step();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
